// File: rtl/ecc_point_arbiter.sv
// Two-requester round-robin front end for a shared point-addition / point-doubling pair.
// Registers the granted operands, arms the units, waits with a timeout and returns one response.
module ecc_point_arbiter #(
    parameter int n       = 231,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req_op,
    input  logic [2*n-1:0] req_x1,
    input  logic [2*n-1:0] req_y1,
    input  logic [2*n-1:0] req_x2,
    input  logic [2*n-1:0] req_y2,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [n-1:0]   rsp_x3,
    output logic [n-1:0]   rsp_y3,
    output logic           rsp_inf,
    output logic           rsp_err,
    output logic           u_rst,
    output logic           u_sel,
    output logic [n-1:0]   u_x1,
    output logic [n-1:0]   u_y1,
    output logic [n-1:0]   u_x2,
    output logic [n-1:0]   u_y2,
    input  logic           add_result,
    input  logic           add_inf,
    input  logic           dbl_result,
    input  logic           dbl_inf,
    input  logic [n-1:0]   add_x3,
    input  logic [n-1:0]   add_y3,
    input  logic [n-1:0]   dbl_x3,
    input  logic [n-1:0]   dbl_y3,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    // Handshake: a request transfers on the rising edge where req_valid[i] and req_ready[i] are both
    // high; a response transfers on the edge where rsp_valid[grant] and rsp_ready[grant] are both high.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         grant_q, grant_d;
    logic         u_sel_q, u_sel_d;
    logic         u_rst_q, u_rst_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [n-1:0] u_x1_q, u_x1_d, u_y1_q, u_y1_d, u_x2_q, u_x2_d, u_y2_q, u_y2_d;
    logic [n-1:0] rsp_x3_q, rsp_x3_d, rsp_y3_q, rsp_y3_d;
    logic         rsp_inf_q, rsp_inf_d, rsp_err_q, rsp_err_d;
    logic [1:0]   rsp_valid_q, rsp_valid_d;

    logic gnt_id, gnt_ok, sel_result;

    always_comb begin
        // On a tie the requester not served last wins; otherwise whoever is valid.
        gnt_id     = (&req_valid) ? ~last_grant_q : ~req_valid[0];
        gnt_ok     = (state_q == S_IDLE) && (|req_valid) && !reset;
        req_ready  = gnt_ok ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        sel_result = u_sel_q ? dbl_result : add_result;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        u_sel_d      = u_sel_q;
        cnt_d        = cnt_q;
        u_x1_d       = u_x1_q;
        u_y1_d       = u_y1_q;
        u_x2_d       = u_x2_q;
        u_y2_d       = u_y2_q;
        rsp_x3_d     = rsp_x3_q;
        rsp_y3_d     = rsp_y3_q;
        rsp_inf_d    = rsp_inf_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_ok) begin
                    u_x1_d       = gnt_id ? req_x1[2*n-1:n] : req_x1[n-1:0];
                    u_y1_d       = gnt_id ? req_y1[2*n-1:n] : req_y1[n-1:0];
                    u_x2_d       = gnt_id ? req_x2[2*n-1:n] : req_x2[n-1:0];
                    u_y2_d       = gnt_id ? req_y2[2*n-1:n] : req_y2[n-1:0];
                    u_sel_d      = gnt_id ? req_op[1] : req_op[0];
                    grant_d      = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = S_ARM;
                end
            end
            S_ARM: begin
                cnt_d   = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A completion in the timeout cycle still wins.
                if (sel_result) begin
                    rsp_x3_d  = u_sel_q ? dbl_x3 : add_x3;
                    rsp_y3_d  = u_sel_q ? dbl_y3 : add_y3;
                    rsp_inf_d = u_sel_q ? dbl_inf : add_inf;
                    rsp_err_d = 1'b0;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_x3_d  = '0;
                    rsp_y3_d  = '0;
                    rsp_inf_d = 1'b0;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[grant_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        u_rst_d     = (state_d != S_WAIT);
        rsp_valid_d = (state_d == S_RESP) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            u_sel_q      <= 1'b0;
            u_rst_q      <= 1'b1;
            cnt_q        <= 16'd0;
            u_x1_q       <= '0;
            u_y1_q       <= '0;
            u_x2_q       <= '0;
            u_y2_q       <= '0;
            rsp_x3_q     <= '0;
            rsp_y3_q     <= '0;
            rsp_inf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            u_sel_q      <= u_sel_d;
            u_rst_q      <= u_rst_d;
            cnt_q        <= cnt_d;
            u_x1_q       <= u_x1_d;
            u_y1_q       <= u_y1_d;
            u_x2_q       <= u_x2_d;
            u_y2_q       <= u_y2_d;
            rsp_x3_q     <= rsp_x3_d;
            rsp_y3_q     <= rsp_y3_d;
            rsp_inf_q    <= rsp_inf_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_x3    = rsp_x3_q;
    assign rsp_y3    = rsp_y3_q;
    assign rsp_inf   = rsp_inf_q;
    assign rsp_err   = rsp_err_q;
    assign u_rst     = u_rst_q;
    assign u_sel     = u_sel_q;
    assign u_x1      = u_x1_q;
    assign u_y1      = u_y1_q;
    assign u_x2      = u_x2_q;
    assign u_y2      = u_y2_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ecc_point_arbiter.sv
// Directed bench for ecc_point_arbiter: a table of single operations against a latency-programmable
// unit model, plus hand sequences for reset, round-robin and reset-during-wait.
module tb_ecc_point_arbiter;
    localparam int N  = 16;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [1:0]     req_valid, req_ready, req_op, rsp_valid, rsp_ready, dbg_state;
    logic [2*N-1:0] req_x1, req_y1, req_x2, req_y2;
    logic [N-1:0]   rsp_x3, rsp_y3, u_x1, u_y1, u_x2, u_y2;
    logic [N-1:0]   add_x3, add_y3, dbl_x3, dbl_y3;
    logic           rsp_inf, rsp_err, u_rst, u_sel, busy;
    logic           add_result, add_inf, dbl_result, dbl_inf;

    always #5 clk = ~clk;

    ecc_point_arbiter #(.n(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x1(req_x1), .req_y1(req_y1), .req_x2(req_x2), .req_y2(req_y2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x3(rsp_x3), .rsp_y3(rsp_y3), .rsp_inf(rsp_inf), .rsp_err(rsp_err),
        .u_rst(u_rst), .u_sel(u_sel),
        .u_x1(u_x1), .u_y1(u_y1), .u_x2(u_x2), .u_y2(u_y2),
        .add_result(add_result), .add_inf(add_inf), .dbl_result(dbl_result), .dbl_inf(dbl_inf),
        .add_x3(add_x3), .add_y3(add_y3), .dbl_x3(dbl_x3), .dbl_y3(dbl_y3),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Unit model: the selected unit completes in its cur_lat-th cycle out of reset (0 = never);
    // the other unit shows inverted data and, with cur_decoy, a spurious completion level.
    int           cur_lat = 2;
    logic         cur_op = 1'b0, cur_decoy = 1'b0, cur_inf = 1'b0;
    logic [N-1:0] cur_x3 = '0, cur_y3 = '0;
    int           ucnt = 0;
    logic         done;

    always @(posedge clk) ucnt <= u_rst ? 0 : ucnt + 1;

    assign done       = !u_rst && cur_lat != 0 && ucnt >= cur_lat - 1;
    assign add_result = cur_op ? (cur_decoy && !u_rst) : done;
    assign dbl_result = cur_op ? done : 1'b0;
    assign add_x3     = cur_op ? ~cur_x3 : cur_x3;
    assign add_y3     = cur_op ? ~cur_y3 : cur_y3;
    assign add_inf    = cur_op ? ~cur_inf : cur_inf;
    assign dbl_x3     = cur_op ? cur_x3 : ~cur_x3;
    assign dbl_y3     = cur_op ? cur_y3 : ~cur_y3;
    assign dbl_inf    = cur_op ? cur_inf : ~cur_inf;

    typedef struct {
        int           r;
        logic         op;
        logic [N-1:0] x1, y1, x2, y2;
        int           lat;
        logic [N-1:0] ux3, uy3;
        logic         uinf;
        logic         decoy;
        int           hold;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_accept(input int r, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready[r]) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
    endtask

    task automatic drain();
        rsp_ready = 2'b11;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("drain_idle", busy, 0);
        rsp_ready = 2'b00;
    endtask

    task automatic do_op(input int i);
        vec_t         v;
        bit           ok;
        int           wcyc, vcyc, bad_rdy, other_v, stab, exp_wait;
        logic         exp_err;
        logic [N-1:0] fx3, fy3;
        logic         finf, ferr;
        v = vecs[i];
        cur_lat = v.lat; cur_op = v.op; cur_decoy = v.decoy;
        cur_x3 = v.ux3; cur_y3 = v.uy3; cur_inf = v.uinf;
        exp_err  = (v.lat == 0 || v.lat > TO);
        exp_wait = exp_err ? TO : v.lat;
        req_op[v.r] = v.op;
        req_x1[v.r*N +: N] = v.x1; req_y1[v.r*N +: N] = v.y1;
        req_x2[v.r*N +: N] = v.x2; req_y2[v.r*N +: N] = v.y2;
        req_valid = 2'b00; req_valid[v.r] = 1'b1;
        rsp_ready = 2'b00; rsp_ready[1-v.r] = 1'b1;
        wait_accept(v.r, ok);
        chk($sformatf("v%0d_accept", i), ok, 1);
        req_valid = 2'b11;
        chk($sformatf("v%0d_arm_state", i), dbg_state, 1);
        chk($sformatf("v%0d_arm_urst", i), u_rst, 1);
        chk($sformatf("v%0d_u_sel", i), u_sel, v.op);
        chk($sformatf("v%0d_u_ops", i), {u_x1, u_y1, u_x2, u_y2}, {v.x1, v.y1, v.x2, v.y2});
        wcyc = 0; vcyc = 0; bad_rdy = 0; other_v = 0; stab = 0;
        fx3 = '0; fy3 = '0; finf = 1'b0; ferr = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy && req_ready != 2'b00) bad_rdy++;
            if (rsp_valid[1-v.r]) other_v++;
            if (!u_rst) wcyc++;
            if (rsp_valid[v.r]) begin
                if (vcyc == 0) begin
                    fx3 = rsp_x3; fy3 = rsp_y3; finf = rsp_inf; ferr = rsp_err;
                end else if ({rsp_x3, rsp_y3, rsp_inf, rsp_err} !== {fx3, fy3, finf, ferr}) begin
                    stab++;
                end
                vcyc++;
                rsp_ready[v.r] = (vcyc > v.hold);
            end else if (vcyc > 0) begin
                break;
            end
        end
        req_valid = 2'b00; rsp_ready = 2'b00;
        chk($sformatf("v%0d_wait_cycles", i), wcyc, exp_wait);
        chk($sformatf("v%0d_valid_cycles", i), vcyc, v.hold + 1);
        chk($sformatf("v%0d_rsp_err", i), ferr, exp_err);
        chk($sformatf("v%0d_rsp_x3", i), fx3, exp_err ? '0 : v.ux3);
        chk($sformatf("v%0d_rsp_y3", i), fy3, exp_err ? '0 : v.uy3);
        chk($sformatf("v%0d_rsp_inf", i), finf, exp_err ? 1'b0 : v.uinf);
        chk($sformatf("v%0d_stable", i), stab, 0);
        chk($sformatf("v%0d_no_ready_busy", i), bad_rdy, 0);
        chk($sformatf("v%0d_other_valid", i), other_v, 0);
    endtask

    int   g;
    logic grants[4];
    bit   ok;

    initial begin
        //          r  op    x1       y1       x2       y2      lat  ux3      uy3      inf  decoy hold
        vecs[0] = '{0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 5, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0, 0};
        vecs[1] = '{1, 1'b1, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 3, 16'h1234, 16'h5678, 1'b0, 1'b0, 3};
        vecs[2] = '{0, 1'b0, 16'hF00D, 16'hBEEF, 16'hCAFE, 16'hD00D, 0, 16'h9999, 16'h7777, 1'b1, 1'b0, 0};
        vecs[3] = '{1, 1'b1, 16'h5555, 16'h6666, 16'h0000, 16'h0000, 4, 16'h4321, 16'h8765, 1'b1, 1'b1, 0};
        vecs[4] = '{0, 1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1, 16'h00FF, 16'hFF00, 1'b1, 1'b0, 0};
        vecs[5] = '{1, 1'b0, 16'hABCD, 16'hEF01, 16'h2345, 16'h6789, 8, 16'h1357, 16'h2468, 1'b0, 1'b0, 1};
        vecs[6] = '{0, 1'b1, 16'h7E7E, 16'h8181, 16'hFFFF, 16'hFFFF, 7, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1};

        req_valid = 2'b00; req_op = 2'b00; rsp_ready = 2'b00;
        req_x1 = '0; req_y1 = '0; req_x2 = '0; req_y2 = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        req_valid = 2'b11;
        #1 chk("ready_in_reset", req_ready, 2'b00);
        @(negedge clk);
        chk("rst_state", dbg_state, 0);
        chk("rst_urst", u_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_inf}, 0);
        chk("rst_data", {u_x1, u_y1, u_x2, u_y2, rsp_x3, rsp_y3}, 0);

        // Round robin with both requesters held valid from reset release.
        rsp_ready = 2'b11; cur_lat = 2; cur_op = 1'b0; req_op = 2'b00;
        reset = 1'b0;
        #1 chk("ready_after_reset", req_ready, 2'b01);
        g = 0;
        for (int k = 0; k < 200 && g < 4; k++) begin
            #1;
            if (req_ready != 2'b00) begin
                grants[g] = req_ready[1];
                g++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("rr_count", g, 4);
        chk("rr_grants", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
        drain();

        // Reset pulsed mid-WAIT abandons the operation.
        cur_lat = 0; cur_op = 1'b0; req_op = 2'b00; rsp_ready = 2'b11;
        req_valid = 2'b01;
        wait_accept(0, ok);
        chk("rmw_accept", ok, 1);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk("rmw_in_wait", dbg_state, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("rmw_urst", u_rst, 1);
        chk("rmw_busy", busy, 0);
        chk("rmw_no_rsp", rsp_valid, 2'b00);
        reset = 1'b0; req_valid = 2'b10; req_op = 2'b00; cur_lat = 2;
        #1 chk("rmw_ready_first", req_ready, 2'b10);
        @(negedge clk);
        chk("rmw_armed", dbg_state, 1);
        req_valid = 2'b00;
        drain();

        for (int i = 0; i < 7; i++) do_op(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
